alu_share_ctrl: RTL and testbench

//  Shares one registered 4-bit ALU (3-bit op select, A, B, carry-in -> result, carry-out) between two requesters.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_share_ctrl_rr_arb2.sv | 14 +
 rtl/alu_share_ctrl.sv | 175 +++++++++++++++++
 tb/tb_alu_share_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op codes and controller state encoding for the ALU sharing controller.
package alu_pkg;

   localparam logic [2:0] OP_NOTA = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_AND  = 3'b010;
   localparam logic [2:0] OP_OR   = 3'b011;
   localparam logic [2:0] OP_XOR  = 3'b100;
   localparam logic [2:0] OP_ROTC = 3'b101;
   localparam logic [2:0] OP_ZERO = 3'b110;
   localparam logic [2:0] OP_ONES = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } share_state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way round-robin grant decode; the pointer register lives in the caller.
module rr_arb2 (
   input  logic valid0,
   input  logic valid1,
   input  logic rr_ptr,
   output logic gnt_valid,
   output logic gnt_id
);

   // Pointer only matters on a tie; a lone requester always wins.
   assign gnt_valid = valid0 | valid1;
   assign gnt_id    = (valid0 & valid1) ? rr_ptr : valid1;

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU between two valid/ready requesters with round-robin arbitration.
// state | meaning
// IDLE  | arbitrating; the grantee is accepted this cycle
// WAIT  | operands issued, counting out the ALU register latency
// RESP  | response held on rsp[gnt_id] until its requester consumes it
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int WIDTH   = 4,
   parameter int ALU_LAT = 1,
   parameter int CNT_W   = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_cout,
   output logic [2:0]       alu_sel,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_cout,
   output logic             busy,
   output logic [CNT_W-1:0] ops_done
);

   localparam int WCNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

   share_state_t     state_q, state_d;
   logic             rr_ptr_q, rr_ptr_d;
   logic             gnt_id_q, gnt_id_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [2:0]       alu_sel_q, alu_sel_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic             alu_cin_q, alu_cin_d;
   logic             rsp0_valid_q, rsp0_valid_d;
   logic             rsp1_valid_q, rsp1_valid_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_cout_q, rsp_cout_d;
   logic [CNT_W-1:0] ops_done_q, ops_done_d;
   logic             busy_q, busy_d;

   logic gnt_valid;
   logic gnt_id;
   logic accept;
   logic rsp_take;

   rr_arb2 u_arb (
      .valid0    (req0_valid),
      .valid1    (req1_valid),
      .rr_ptr    (rr_ptr_q),
      .gnt_valid (gnt_valid),
      .gnt_id    (gnt_id)
   );

   // Ready is masked during reset so no handshake is ever seen while state is being cleared.
   assign accept     = ~reset & (state_q == IDLE) & gnt_valid;
   assign req0_ready = accept & ~gnt_id;
   assign req1_ready = accept & gnt_id;
   assign rsp_take   = gnt_id_q ? rsp1_ready : rsp0_ready;

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_id_d     = gnt_id_q;
      wait_cnt_d   = wait_cnt_q;
      alu_sel_d    = alu_sel_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_cin_d    = alu_cin_q;
      rsp0_valid_d = rsp0_valid_q;
      rsp1_valid_d = rsp1_valid_q;
      rsp_result_d = rsp_result_q;
      rsp_cout_d   = rsp_cout_q;
      ops_done_d   = ops_done_q;
      case (state_q)
         IDLE: begin
            if (gnt_valid) begin
               alu_sel_d  = gnt_id ? req1_op  : req0_op;
               alu_a_d    = gnt_id ? req1_a   : req0_a;
               alu_b_d    = gnt_id ? req1_b   : req0_b;
               alu_cin_d  = gnt_id ? req1_cin : req0_cin;
               wait_cnt_d = WCNT_W'(ALU_LAT);
               gnt_id_d   = gnt_id;
               rr_ptr_d   = ~gnt_id;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt_q != '0) begin
               wait_cnt_d = wait_cnt_q - WCNT_W'(1);
            end else begin
               rsp_result_d = alu_result;
               rsp_cout_d   = alu_cout;
               rsp0_valid_d = ~gnt_id_q;
               rsp1_valid_d = gnt_id_q;
               state_d      = RESP;
            end
         end
         RESP: begin
            if (rsp_take) begin
               rsp0_valid_d = 1'b0;
               rsp1_valid_d = 1'b0;
               ops_done_d   = ops_done_q + CNT_W'(1);
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         rr_ptr_q     <= 1'b0;
         gnt_id_q     <= 1'b0;
         wait_cnt_q   <= '0;
         alu_sel_q    <= OP_ZERO;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_cin_q    <= 1'b0;
         rsp0_valid_q <= 1'b0;
         rsp1_valid_q <= 1'b0;
         rsp_result_q <= '0;
         rsp_cout_q   <= 1'b0;
         ops_done_q   <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_id_q     <= gnt_id_d;
         wait_cnt_q   <= wait_cnt_d;
         alu_sel_q    <= alu_sel_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_cin_q    <= alu_cin_d;
         rsp0_valid_q <= rsp0_valid_d;
         rsp1_valid_q <= rsp1_valid_d;
         rsp_result_q <= rsp_result_d;
         rsp_cout_q   <= rsp_cout_d;
         ops_done_q   <= ops_done_d;
         busy_q       <= busy_d;
      end
   end

   assign alu_sel    = alu_sel_q;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_cin    = alu_cin_q;
   assign rsp0_valid = rsp0_valid_q;
   assign rsp1_valid = rsp1_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_cout   = rsp_cout_q;
   assign ops_done   = ops_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Self-checking bench for alu_share_ctrl driving a registered 4-bit ALU (one cycle latency).
module tb_alu_share_ctrl;
   import alu_pkg::*;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
   logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
   logic       req0_cin = 1'b0, req1_cin = 1'b0;
   logic       rsp0_valid, rsp1_valid;
   logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
   logic [3:0] rsp_result;
   logic       rsp_cout;
   logic [2:0] alu_sel;
   logic [3:0] alu_a, alu_b;
   logic       alu_cin;
   logic [3:0] alu_result = 4'd0;
   logic       alu_cout = 1'b0;
   logic       busy;
   logic [7:0] ops_done;

   int   checks = 0;
   int   errors = 0;
   bit   rr_m = 1'b0;
   logic [7:0] ops_m = 8'd0;

   always #5 clock = ~clock;

   alu_share_ctrl #(.WIDTH(4), .ALU_LAT(1), .CNT_W(8)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_cout(rsp_cout),
      .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_result(alu_result), .alu_cout(alu_cout),
      .busy(busy), .ops_done(ops_done)
   );

   // Arithmetic view of the ALU: returns {cout, result}.
   function automatic logic [4:0] ref_alu(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b, input logic cin);
      int s;
      case (op)
         OP_NOTA: s = 15 - int'(a);
         OP_ADD:  s = int'(a) + int'(b) + int'(cin);
         OP_AND:  s = int'(a & b);
         OP_OR:   s = int'(a | b);
         OP_XOR:  s = int'(a ^ b);
         OP_ROTC: s = int'(a) * 2 + int'(cin);
         OP_ZERO: s = 0;
         default: s = 15;
      endcase
      return s[4:0];
   endfunction

   always_ff @(posedge clock) {alu_cout, alu_result} <= ref_alu(alu_sel, alu_a, alu_b, alu_cin);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input bit n, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic cin);
      if (n) begin
         req1_op = op; req1_a = a; req1_b = b; req1_cin = cin;
      end else begin
         req0_op = op; req0_a = a; req0_b = b; req0_cin = cin;
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'(0));
      chk({tag, "_ready0"}, 32'(req0_ready), 32'(0));
      chk({tag, "_ready1"}, 32'(req1_ready), 32'(0));
      chk({tag, "_rsp0v"}, 32'(rsp0_valid), 32'(0));
      chk({tag, "_rsp1v"}, 32'(rsp1_valid), 32'(0));
      chk({tag, "_sel"}, 32'(alu_sel), 32'(OP_ZERO));
      chk({tag, "_ops"}, 32'(ops_done), 32'(0));
   endtask

   // Entered and left just after a falling edge; performs one full operation.
   task automatic txn(input bit v0, input bit v1, input int stall);
      bit         g;
      logic [4:0] e;
      logic [2:0] e_sel;
      logic [3:0] e_a;
      req0_valid = v0; req1_valid = v1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      #1;
      g = (v0 && v1) ? rr_m : v1;
      chk("grant0", 32'(req0_ready), 32'(g == 1'b0));
      chk("grant1", 32'(req1_ready), 32'(g == 1'b1));
      e     = g ? ref_alu(req1_op, req1_a, req1_b, req1_cin) : ref_alu(req0_op, req0_a, req0_b, req0_cin);
      e_sel = g ? req1_op : req0_op;
      e_a   = g ? req1_a : req0_a;
      rr_m  = ~g;
      ops_m = ops_m + 8'd1;
      @(posedge clock); #1;
      if (g) req1_valid = 1'b0; else req0_valid = 1'b0;
      set_req(g, 3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      for (int k = 0; k < 2; k++) begin
         @(negedge clock);
         chk("wait_busy", 32'(busy), 32'(1));
         chk("wait_ready", 32'({req0_ready, req1_ready}), 32'(0));
         chk("wait_rspv", 32'({rsp0_valid, rsp1_valid}), 32'(0));
         chk("alu_sel", 32'(alu_sel), 32'(e_sel));
         chk("alu_a", 32'(alu_a), 32'(e_a));
      end
      @(negedge clock);
      chk("rsp_route", 32'({rsp1_valid, rsp0_valid}), g ? 32'(2) : 32'(1));
      chk("rsp_result", 32'(rsp_result), 32'(e[3:0]));
      chk("rsp_cout", 32'(rsp_cout), 32'(e[4]));
      for (int k = 0; k < stall; k++) begin
         if (g) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
         @(negedge clock);
         chk("stall_route", 32'({rsp1_valid, rsp0_valid}), g ? 32'(2) : 32'(1));
         chk("stall_result", 32'({rsp_cout, rsp_result}), 32'(e));
         chk("stall_ready", 32'({req0_ready, req1_ready}), 32'(0));
         chk("stall_alu_sel", 32'(alu_sel), 32'(e_sel));
      end
      rsp0_ready = ~g; rsp1_ready = g;
      @(posedge clock); #1;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      @(negedge clock);
      chk("drain_rspv", 32'({rsp0_valid, rsp1_valid}), 32'(0));
      chk("drain_busy", 32'(busy), 32'(0));
      chk("ops_done", 32'(ops_done), 32'(ops_m));
      chk("hold_alu_sel", 32'(alu_sel), 32'(e_sel));
   endtask

   initial begin
      // Reset, checked on every cycle it is held.
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk_reset_state("reset");
      end
      reset = 1'b0;

      set_req(0, OP_ADD, 4'b0101, 4'b0101, 1'b0);
      txn(1'b1, 1'b0, 0);
      chk("add_0101", 32'(rsp_result), 32'(4'b1010));
      set_req(1, OP_ADD, 4'b1111, 4'b1111, 1'b1);
      txn(1'b0, 1'b1, 0);
      chk("add_carry", 32'({rsp_cout, rsp_result}), 32'(5'b11111));

      // Both continuously valid: alternate grants.
      for (int i = 0; i < 8; i++) begin
         set_req(0, OP_XOR, 4'b1111, 4'b0000, 1'b0);
         set_req(1, OP_AND, 4'b1111, 4'b0000, 1'b0);
         txn(1'b1, 1'b1, 0);
         chk("alt_result", 32'(rsp_result), (i % 2 == 0) ? 32'(4'b1111) : 32'(4'b0000));
      end

      // Back-pressure on response 0 while requester 1 waits.
      set_req(0, OP_OR, 4'b1010, 4'b0101, 1'b0);
      set_req(1, OP_NOTA, 4'b0011, 4'b0000, 1'b0);
      txn(1'b1, 1'b1, 5);

      // Random traffic, long enough to wrap ops_done.
      for (int i = 0; i < 270; i++) begin
         int pat;
         pat = int'($urandom_range(1, 3));
         set_req(0, 3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
         set_req(1, 3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
         txn(pat[0], pat[1], int'($urandom_range(0, 2)));
      end

      // Reset while an operation is in WAIT.
      set_req(0, OP_ADD, 4'd3, 4'd4, 1'b0);
      req0_valid = 1'b1; req1_valid = 1'b0;
      @(posedge clock); #1;
      req0_valid = 1'b0; req1_valid = 1'b1; reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         @(negedge clock);
         chk_reset_state("midreset");
      end
      req1_valid = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      rr_m  = 1'b0;
      ops_m = 8'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("post_reset_rspv", 32'({rsp0_valid, rsp1_valid}), 32'(0));
         chk("post_reset_busy", 32'(busy), 32'(0));
      end
      set_req(0, OP_ONES, 4'd0, 4'd0, 1'b0);
      txn(1'b1, 1'b0, 0);
      chk("ones_result", 32'(rsp_result), 32'(4'b1111));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
